// File: rtl/simon_pkg.sv
// Shared definitions for the Simon game controller: state encoding and mode LED patterns.
package simon_pkg;

    typedef enum logic [1:0] {
        ST_INPUT    = 2'd0,
        ST_PLAYBACK = 2'd1,
        ST_REPEAT   = 2'd2,
        ST_DONE     = 2'd3
    } state_t;

    localparam logic [2:0] LED_MODE_INPUT    = 3'b001;
    localparam logic [2:0] LED_MODE_PLAYBACK = 3'b010;
    localparam logic [2:0] LED_MODE_REPEAT   = 3'b100;
    localparam logic [2:0] LED_MODE_DONE     = 3'b111;

endpackage

// File: rtl/simon_control.sv
// Simon game control FSM: sequences INPUT -> PLAYBACK -> REPEAT (-> INPUT or DONE)
// and drives the datapath strobes combinationally from state and status flags.
module simon_control
    import simon_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       valid_input,
    input  logic       valid_repeat,
    input  logic       seq_remain,
    output logic       clear_i,
    output logic       increment_n,
    output logic       increment_i,
    output logic       input_led_pattern,
    output logic       write_pattern,
    output logic [2:0] mode_leds
);

    state_t state_q;
    state_t state_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_INPUT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d           = state_q;
        clear_i           = 1'b0;
        increment_n       = 1'b0;
        increment_i       = 1'b0;
        write_pattern     = 1'b0;
        input_led_pattern = 1'b1;
        mode_leds         = LED_MODE_INPUT;

        case (state_q)
            ST_INPUT: begin
                write_pattern = valid_input;
                increment_n   = valid_input;
                clear_i       = valid_input;
                if (valid_input) begin
                    state_d = ST_PLAYBACK;
                end
            end

            ST_PLAYBACK: begin
                mode_leds         = LED_MODE_PLAYBACK;
                input_led_pattern = 1'b0;
                increment_i       = seq_remain;
                clear_i           = !seq_remain;
                if (!seq_remain) begin
                    state_d = ST_REPEAT;
                end
            end

            ST_REPEAT: begin
                mode_leds = LED_MODE_REPEAT;
                // A wrong guess wins over the remaining-entries flag.
                if (!valid_repeat) begin
                    clear_i = 1'b1;
                    state_d = ST_DONE;
                end else if (seq_remain) begin
                    increment_i = 1'b1;
                end else begin
                    state_d = ST_INPUT;
                end
            end

            ST_DONE: begin
                mode_leds         = LED_MODE_DONE;
                input_led_pattern = 1'b0;
                increment_i       = seq_remain;
                clear_i           = !seq_remain;
            end

            default: begin
                state_d = ST_INPUT;
            end
        endcase
    end

endmodule

// File: tb/tb_simon_control.sv
// Self-checking bench for simon_control: a game-level model checked every cycle,
// plus directed literal expectations walking through the play sequence.
module tb_simon_control;

    logic       clk = 1'b0;
    logic       rst;
    logic       valid_input;
    logic       valid_repeat;
    logic       seq_remain;
    logic       clear_i;
    logic       increment_n;
    logic       increment_i;
    logic       input_led_pattern;
    logic       write_pattern;
    logic [2:0] mode_leds;

    int n_pass  = 0;
    int n_total = 0;

    simon_control dut (
        .clk              (clk),
        .rst              (rst),
        .valid_input      (valid_input),
        .valid_repeat     (valid_repeat),
        .seq_remain       (seq_remain),
        .clear_i          (clear_i),
        .increment_n      (increment_n),
        .increment_i      (increment_i),
        .input_led_pattern(input_led_pattern),
        .write_pattern    (write_pattern),
        .mode_leds        (mode_leds)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Game model: phase 0=entering, 1=showing, 2=guessing, 3=game over.
    int   m_phase = 0;
    bit   model_on = 1'b0;
    logic [2:0] led_of_phase [4] = '{3'b001, 3'b010, 3'b100, 3'b111};

    always @(posedge clk) begin
        if (rst) begin
            m_phase  <= 0;
            model_on <= 1'b1;
        end else if (model_on) begin
            if (m_phase == 0 && valid_input)                     m_phase <= 1;
            else if (m_phase == 1 && !seq_remain)                m_phase <= 2;
            else if (m_phase == 2 && !valid_repeat)              m_phase <= 3;
            else if (m_phase == 2 && valid_repeat && !seq_remain) m_phase <= 0;
        end
    end

    always @(negedge clk) begin
        if (model_on) begin
            logic e_clr, e_inci, e_incn, e_wp, e_ilp;
            e_clr  = 1'b0;
            e_inci = 1'b0;
            e_incn = (m_phase == 0) && valid_input;
            e_wp   = (m_phase == 0) && valid_input;
            e_ilp  = (m_phase == 0) || (m_phase == 2);
            if (m_phase == 0) e_clr = valid_input;
            if (m_phase == 1 || m_phase == 3) begin
                e_inci = seq_remain;
                e_clr  = !seq_remain;
            end
            if (m_phase == 2) begin
                e_clr  = !valid_repeat;
                e_inci = valid_repeat && seq_remain;
            end
            chk("model_mode_leds", mode_leds, led_of_phase[m_phase]);
            chk("model_input_led_pattern", {2'b0, input_led_pattern}, {2'b0, e_ilp});
            chk("model_clear_i", {2'b0, clear_i}, {2'b0, e_clr});
            chk("model_increment_i", {2'b0, increment_i}, {2'b0, e_inci});
            chk("model_increment_n", {2'b0, increment_n}, {2'b0, e_incn});
            chk("model_write_pattern", {2'b0, write_pattern}, {2'b0, e_wp});
            chk("model_strobe_exclusive", {2'b0, clear_i & increment_i}, 3'b000);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; valid_input = 1'b0; valid_repeat = 1'b0; seq_remain = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        chk("reset_mode", mode_leds, 3'b001);
        chk("reset_ilp", {2'b0, input_led_pattern}, 3'b001);
        chk("reset_clear_i", {2'b0, clear_i}, 3'b000);
        chk("reset_increment_n", {2'b0, increment_n}, 3'b000);
        chk("reset_write_pattern", {2'b0, write_pattern}, 3'b000);

        tick();
        chk("invalid_input_mode", mode_leds, 3'b001);
        chk("invalid_input_incn", {2'b0, increment_n}, 3'b000);
        valid_input = 1'b1; #1;
        chk("valid_input_incn", {2'b0, increment_n}, 3'b001);
        chk("valid_input_wp", {2'b0, write_pattern}, 3'b001);
        tick();
        valid_input = 1'b0; seq_remain = 1'b0; #1;
        chk("playback_mode", mode_leds, 3'b010);
        chk("playback_ilp", {2'b0, input_led_pattern}, 3'b000);
        chk("playback_clear_end", {2'b0, clear_i}, 3'b001);

        seq_remain = 1'b1; #1;
        chk("playback_inci", {2'b0, increment_i}, 3'b001);
        chk("playback_clear_mid", {2'b0, clear_i}, 3'b000);
        tick();
        chk("playback_stays", mode_leds, 3'b010);
        seq_remain = 1'b0; #1;
        chk("playback_clear_last", {2'b0, clear_i}, 3'b001);
        tick();
        chk("repeat_mode", mode_leds, 3'b100);
        chk("repeat_ilp", {2'b0, input_led_pattern}, 3'b001);

        valid_repeat = 1'b1; seq_remain = 1'b1; #1;
        chk("repeat_inci", {2'b0, increment_i}, 3'b001);
        tick();
        chk("repeat_stays", mode_leds, 3'b100);
        seq_remain = 1'b0; valid_input = 1'b0; #1;
        chk("repeat_last_no_strobe", {1'b0, clear_i, increment_i}, 3'b000);
        tick();
        chk("back_to_input", mode_leds, 3'b001);
        chk("back_to_input_clr", {2'b0, clear_i}, 3'b000);

        valid_input = 1'b1; tick();
        valid_input = 1'b0; seq_remain = 1'b0; tick();
        chk("repeat_again", mode_leds, 3'b100);
        valid_repeat = 1'b0; seq_remain = 1'b1; #1;
        chk("wrong_guess_clr", {2'b0, clear_i}, 3'b001);
        chk("wrong_guess_inci", {2'b0, increment_i}, 3'b000);
        tick();
        chk("done_mode", mode_leds, 3'b111);
        chk("done_ilp", {2'b0, input_led_pattern}, 3'b000);
        for (int k = 0; k < 6; k++) begin
            seq_remain = k[0]; valid_input = 1'b1; valid_repeat = ~k[0]; #1;
            chk("done_inci", {2'b0, increment_i}, {2'b0, k[0]});
            chk("done_clr", {2'b0, clear_i}, {2'b0, ~k[0]});
            tick();
            chk("done_stays", mode_leds, 3'b111);
        end

        rst = 1'b1; tick(); rst = 1'b0; valid_input = 1'b0; #1;
        chk("reset_from_done", mode_leds, 3'b001);

        valid_input = 1'b1; tick();
        rst = 1'b1; tick(); rst = 1'b0; valid_input = 1'b0; #1;
        chk("reset_from_playback", mode_leds, 3'b001);

        for (int k = 0; k < 300; k++) begin
            rst          = ($urandom_range(0, 39) == 0);
            valid_input  = $urandom_range(0, 1);
            valid_repeat = ($urandom_range(0, 3) != 0);
            seq_remain   = $urandom_range(0, 1);
            tick();
        end
        rst = 1'b0;
        tick();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
